// File: rtl/score_display_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : score_display_unit_if
//  Description : Game-state / score bus between the game datapath and the
//                score display unit (BCD, segment and anchor outputs).
//  Revision    : 1.0 - initial release
// ============================================================================
interface score_display_unit_if #(
    parameter int BIN_WIDTH = 32,
    parameter int DIGITS    = 6
);
    logic [3:0]           game_state;
    logic [BIN_WIDTH-1:0] score_count;
    logic [4*DIGITS-1:0]  score_BCD;
    logic [4*DIGITS-1:0]  hiscore_BCD;
    logic                 bcd_valid;
    logic                 overflow;
    logic                 new_hiscore;
    logic [7*DIGITS-1:0]  seven_seg;
    logic [9:0]           scoreX;
    logic [8:0]           scoreY;

    // Game logic side
    modport master (
        output game_state, score_count,
        input  score_BCD, hiscore_BCD, bcd_valid, overflow, new_hiscore,
               seven_seg, scoreX, scoreY
    );

    // Display unit side
    modport slave (
        input  game_state, score_count,
        output score_BCD, hiscore_BCD, bcd_valid, overflow, new_hiscore,
               seven_seg, scoreX, scoreY
    );
endinterface
`default_nettype wire

// File: rtl/score_display_unit.sv
`default_nettype none
// ============================================================================
//  Module      : score_display_unit
//  Description : Score / high-score tracker with a shared round-robin
//                double-dabble BCD converter, active-low seven-segment
//                driver (leading-zero blanking, pause blink) and score
//                anchor coordinates.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_display_unit #(
    parameter int         BIN_WIDTH  = 32,
    parameter int         DIGITS     = 6,
    parameter int         BLINK_LOG2 = 25,
    parameter logic [9:0] X_GAME     = 10'd560,
    parameter logic [8:0] Y_GAME     = 9'd16,
    parameter logic [9:0] X_END      = 10'd272,
    parameter logic [8:0] Y_END      = 9'd232
) (
    input  wire logic          clk,
    input  wire logic          rst,
    score_display_unit_if.slave bus
);
    localparam logic [3:0] c_start = 4'b0001;
    localparam logic [3:0] c_game  = 4'b0010;
    localparam logic [3:0] c_pause = 4'b0100;
    localparam logic [3:0] c_end   = 4'b1000;

    // Internal BCD register: enough digits for any BIN_WIDTH operand, never
    // fewer than DIGITS, plus one spare so saturation detection always has
    // at least one digit above the displayed ones.
    localparam int c_bcd_nat    = (BIN_WIDTH * 30103) / 100000 + 1;
    localparam int c_bcd_digits = ((c_bcd_nat > DIGITS) ? c_bcd_nat : DIGITS) + 1;
    localparam int c_bcd_w      = 4 * c_bcd_digits;
    localparam int c_cnt_w      = $clog2(BIN_WIDTH + 1);
    localparam int c_blink_w    = BLINK_LOG2 + 1;

    typedef enum logic [1:0] {
        CV_IDLE  = 2'd0,
        CV_LOAD  = 2'd1,
        CV_SHIFT = 2'd2,
        CV_DONE  = 2'd3
    } cv_state_e;

    logic [3:0]           prev_q, prev_d;
    logic [BIN_WIDTH-1:0] score_q, score_d;
    logic [BIN_WIDTH-1:0] hiscore_q, hiscore_d;
    logic                 new_hi_q, new_hi_d;
    logic [9:0]           x_q, x_d;
    logic [8:0]           y_q, y_d;
    cv_state_e            cv_q, cv_d;
    logic                 sel_q, sel_d;       // 0: score operand, 1: hiscore
    logic [BIN_WIDTH-1:0] opnd_q, opnd_d;
    logic [c_bcd_w-1:0]   sh_q, sh_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [4*DIGITS-1:0]  score_bcd_q, score_bcd_d;
    logic [4*DIGITS-1:0]  hi_bcd_q, hi_bcd_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic [c_blink_w-1:0] blink_q, blink_d;
    logic [7*DIGITS-1:0]  seg_q, seg_d;

    logic                 w_onehot;
    logic [c_bcd_w-1:0]   w_adj;
    logic                 w_sat;
    logic [4*DIGITS-1:0]  w_result;
    logic [4*DIGITS-1:0]  w_src;
    logic                 w_blank_all;
    logic                 w_nz;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'h40;
            4'd1:    seg_encode = 7'h79;
            4'd2:    seg_encode = 7'h24;
            4'd3:    seg_encode = 7'h30;
            4'd4:    seg_encode = 7'h19;
            4'd5:    seg_encode = 7'h12;
            4'd6:    seg_encode = 7'h02;
            4'd7:    seg_encode = 7'h78;
            4'd8:    seg_encode = 7'h00;
            4'd9:    seg_encode = 7'h10;
            default: seg_encode = 7'h7F;
        endcase
    endfunction

    // Game-state tracking: score, high score, edge detect and anchor position
    always_comb begin
        prev_d    = prev_q;
        score_d   = score_q;
        hiscore_d = hiscore_q;
        new_hi_d  = new_hi_q;
        x_d       = x_q;
        y_d       = y_q;
        w_onehot  = (bus.game_state == c_start) || (bus.game_state == c_game) ||
                    (bus.game_state == c_pause) || (bus.game_state == c_end);
        if (w_onehot) begin
            prev_d = bus.game_state;
            if (bus.game_state == c_game) begin
                score_d = (prev_q == c_start) ? '0 : bus.score_count;
            end
            if (bus.game_state == c_end) begin
                if (prev_q != c_end) begin
                    new_hi_d = (score_q > hiscore_q);
                    if (score_q > hiscore_q) begin
                        hiscore_d = score_q;
                    end
                end
            end else begin
                new_hi_d = 1'b0;
            end
            x_d = (bus.game_state == c_end) ? X_END : X_GAME;
            y_d = (bus.game_state == c_end) ? Y_END : Y_GAME;
        end
    end

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more
    always_comb begin
        w_adj = sh_q;
        for (int i = 0; i < c_bcd_digits; i++) begin
            if (sh_q[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = sh_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Round-robin converter: alternates score and hiscore, writes result in DONE
    always_comb begin
        cv_d        = cv_q;
        sel_d       = sel_q;
        opnd_d      = opnd_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        score_bcd_d = score_bcd_q;
        hi_bcd_d    = hi_bcd_q;
        valid_d     = valid_q;
        ovf_d       = ovf_q;
        w_sat       = |sh_q[c_bcd_w-1:4*DIGITS];
        w_result    = w_sat ? {DIGITS{4'h9}} : sh_q[4*DIGITS-1:0];
        case (cv_q)
            CV_IDLE: begin
                cv_d = CV_LOAD;
            end
            CV_LOAD: begin
                opnd_d = sel_q ? hiscore_q : score_q;
                sh_d   = '0;
                cnt_d  = '0;
                cv_d   = CV_SHIFT;
            end
            CV_SHIFT: begin
                sh_d   = c_bcd_w'({w_adj, opnd_q[BIN_WIDTH-1]});
                opnd_d = opnd_q << 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == c_cnt_w'(BIN_WIDTH - 1)) begin
                    cv_d = CV_DONE;
                end
            end
            default: begin
                if (sel_q) begin
                    hi_bcd_d = w_result;
                    valid_d  = 1'b1;
                end else begin
                    score_bcd_d = w_result;
                    ovf_d       = w_sat;
                end
                sel_d = ~sel_q;
                cv_d  = CV_IDLE;
            end
        endcase
    end

    // Segment drive: source select, leading-zero blanking, blink and gating
    always_comb begin
        blink_d     = blink_q + 1'b1;
        w_src       = (bus.game_state == c_start) ? hi_bcd_q : score_bcd_q;
        w_blank_all = !valid_q || ((bus.game_state == c_pause) && blink_q[c_blink_w-1]);
        w_nz        = 1'b0;
        seg_d       = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_nz = w_nz | (w_src[4*i +: 4] != 4'd0);
            if (!w_blank_all && (w_nz || (i == 0))) begin
                seg_d[7*i +: 7] = seg_encode(w_src[4*i +: 4]);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= c_start;
            score_q     <= '0;
            hiscore_q   <= '0;
            new_hi_q    <= 1'b0;
            x_q         <= X_GAME;
            y_q         <= Y_GAME;
            cv_q        <= CV_IDLE;
            sel_q       <= 1'b0;
            opnd_q      <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
            score_bcd_q <= '0;
            hi_bcd_q    <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            blink_q     <= '0;
            seg_q       <= '1;
        end else begin
            prev_q      <= prev_d;
            score_q     <= score_d;
            hiscore_q   <= hiscore_d;
            new_hi_q    <= new_hi_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cv_q        <= cv_d;
            sel_q       <= sel_d;
            opnd_q      <= opnd_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            score_bcd_q <= score_bcd_d;
            hi_bcd_q    <= hi_bcd_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
            blink_q     <= blink_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.score_BCD   = score_bcd_q;
    assign bus.hiscore_BCD = hi_bcd_q;
    assign bus.bcd_valid   = valid_q;
    assign bus.overflow    = ovf_q;
    assign bus.new_hiscore = new_hi_q;
    assign bus.seven_seg   = seg_q;
    assign bus.scoreX      = x_q;
    assign bus.scoreY      = y_q;
endmodule
`default_nettype wire

// File: doc/score_display_unit.md
# score_display_unit

Parametrised score tracker and display driver for the game datapath. It tracks the live score and the session high score against the one-hot game state, and converts both to BCD with a shared iterative double-dabble engine. It drives active-low seven-segment digits with leading-zero blanking and pause blinking, and supplies the on-screen score anchor coordinates to the pixel renderer.

## Interface
Parameters:
- BIN_WIDTH, 32, width of binary score input
- DIGITS, 6, BCD digits converted and displayed
- BLINK_LOG2, 25, pause blink half-period is 2^BLINK_LOG2 clk cycles
- X_GAME, 10'd560, score X anchor in START_SCREEN, IN_GAME, PAUSE
- Y_GAME, 9'd16, score Y anchor in START_SCREEN, IN_GAME, PAUSE
- X_END, 10'd272, score X anchor in END_SCREEN
- Y_END, 9'd232, score Y anchor in END_SCREEN

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- game_state  in  4  one-hot: 0001 START_SCREEN, 0010 IN_GAME, 0100 PAUSE, 1000 END_SCREEN
- score_count  in  BIN_WIDTH  live binary score from game logic
- score_BCD  out  4*DIGITS  BCD of latched score, digit 0 in LSBs
- hiscore_BCD  out  4*DIGITS  BCD of high score
- bcd_valid  out  1  high once both BCD outputs hold a completed conversion
- overflow  out  1  latched score exceeds 10^DIGITS-1
- new_hiscore  out  1  current END_SCREEN visit set a new high score
- seven_seg  out  7*DIGITS  active-low segments {g..a} per digit, digit 0 in LSBs
- scoreX  out  10  score anchor X pixel
- scoreY  out  9  score anchor Y pixel

## Operation
- Score register, BIN_WIDTH bits:
  - cleared on START_SCREEN -> IN_GAME;
  - loads score_count every cycle in IN_GAME;
  - holds in PAUSE, END_SCREEN and START_SCREEN.
- Previous-state register detects edges. A non-one-hot game_state holds all state registers and is not recorded as the previous state.
- High score: on the first cycle of END_SCREEN (prev != END_SCREEN), if score > hiscore then hiscore <= score and new_hiscore <= 1. new_hiscore clears on leaving END_SCREEN. Comparison is unsigned. Equal scores do not set the flag.
- Converter FSM: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
  - LOAD snapshots the operand.
  - SHIFT runs BIN_WIDTH iterations of add-3-if->=5, then shift.
  - DONE writes the result.
  - Operands alternate: score, hiscore, score, ...; the FSM restarts immediately.
- Saturation: if the operand > 10^DIGITS-1, the result is all nines (0x999999 for DIGITS=6). When the operand is the score, overflow is set, otherwise cleared on the score result. The internal BCD shift register is at least ceil(BIN_WIDTH*log10(2)) digits wide; only DIGITS digits are output.
- Display source: hiscore_BCD in START_SCREEN, score_BCD otherwise.
- Leading-zero blanking: digits above the most significant nonzero digit are blank (all segments 1). Digit 0 always displays.
- Blinking: a free-running BLINK_LOG2+1-bit counter runs. In PAUSE, all digits blank while the counter MSB is 1.
- Display gating: while bcd_valid=0, all digits blank.
- Segment encoding, active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
- Position: scoreX/scoreY = X_END/Y_END in END_SCREEN, else X_GAME/Y_GAME. Registered.

## Timing
- Reset values:
  - score_BCD = 0, hiscore_BCD = 0;
  - bcd_valid = 0, overflow = 0, new_hiscore = 0;
  - seven_seg all ones;
  - scoreX = X_GAME, scoreY = Y_GAME;
  - score = 0, hiscore = 0;
  - FSM in IDLE, blink counter 0.
- Conversion latency per operand: BIN_WIDTH+2 cycles (LOAD 1, SHIFT BIN_WIDTH, DONE 1). IDLE lasts 1 cycle. Round-robin period is 2*(BIN_WIDTH+3) = 70 cycles at default.
- The BCD outputs update only in DONE, all digits in the same cycle; no partial values are visible.
- bcd_valid rises in the cycle after the first hiscore DONE. Its only fall is on reset.
- score_count -> score register: 1 cycle. Worst-case score_count -> score_BCD: 1 + 2*(BIN_WIDTH+3) cycles.
- seven_seg, scoreX and scoreY are registered: 1 cycle after their source changes.
- The hiscore update and new_hiscore occur in the cycle after END_SCREEN first appears. A conversion in flight completes with its snapshotted operand; the new hiscore appears on the next hiscore pass.
- Reset mid-conversion aborts the conversion. Outputs return to reset values on the next edge.
- IN_GAME -> PAUSE -> IN_GAME leaves the score unchanged except for reloading from score_count.

## Test plan
- Reset, then IN_GAME, score_count = 1234 for 200 cycles -> score_BCD = 0x001234, seven_seg digits 5..4 blank, digit 3 = 7'h79, bcd_valid = 1.
- score_count = 32'hFFFFFFFF in IN_GAME -> score_BCD = 0x999999, overflow = 1. Then START_SCREEN -> IN_GAME with score_count = 7 -> overflow = 0, score_BCD = 0x000007.
- Game to END_SCREEN with score 500, hiscore 0 -> hiscore_BCD = 0x000500 within 140 cycles, new_hiscore = 1, scoreX/scoreY = X_END/Y_END. Replay ending at score 500 -> new_hiscore = 0.
- PAUSE with BLINK_LOG2 = 3 -> seven_seg alternates all-ones / digits every 8 cycles. In IN_GAME, no blinking.
- Assert rst midway through SHIFT after a high score of 900 -> next cycle all outputs at reset values, hiscore_BCD = 0. START_SCREEN shows digit 0 as 7'h40 after bcd_valid.
- game_state = 4'b0011 for 50 cycles -> score, hiscore and scoreX unchanged. Converter continues.
